// File: rtl/mem_arbiter_if.sv
// Bundle of the requester-side (IF/MEM stage) and RAM-side signals of the
// memory arbiter. The arbiter uses the slave modport; the environment
// (requesters plus RAM) uses the master modport.
interface mem_arbiter_if #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 32
);
   // instruction requester
   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   logic              ihit;
   logic [WORD_W-1:0] iload;
   // data requester
   logic              dREN;
   logic              dWEN;
   logic [ADDR_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              dhit;
   logic [WORD_W-1:0] dload;
   // RAM port
   logic              ramREN;
   logic              ramWEN;
   logic [ADDR_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   logic [1:0]        ramstate;
   // status
   logic              err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction-fetch
// and data requesters. One request is latched at a time and driven to the
// RAM until it reports ACCESS; completion is signalled by a one-cycle
// ihit/dhit pulse. Data has priority, but after MAX_DATA_STREAK consecutive
// data grants with a fetch waiting, the fetch is forced through.
module mem_arbiter #(
   parameter int WORD_W          = 32,
   parameter int ADDR_W          = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic         CLK,
   input  logic         RST,
   mem_arbiter_if.slave bus
);
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

   state_t            state_q,  state_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [WORD_W-1:0] store_q,  store_d;
   logic              wr_q,     wr_d;
   logic [3:0]        streak_q, streak_d;
   logic              ihit_q,   ihit_d;
   logic              dhit_q,   dhit_d;
   logic [WORD_W-1:0] iload_q,  iload_d;
   logic [WORD_W-1:0] dload_q,  dload_d;
   logic              err_q,    err_d;

   logic dreq;
   logic force_fetch;

   assign dreq        = bus.dREN | bus.dWEN;
   assign force_fetch = bus.iREN & (streak_q == STREAK_MAX);

   // Next-state logic: grant in IDLE, wait for ACCESS, one RESP cycle for the hit pulse.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      store_d  = store_q;
      wr_d     = wr_q;
      streak_d = streak_q;
      ihit_d   = 1'b0;
      dhit_d   = 1'b0;
      iload_d  = iload_q;
      dload_d  = dload_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (dreq && !force_fetch) begin
               state_d = DACC;
               addr_d  = bus.daddr;
               store_d = bus.dstore;
               // a simultaneous read+write is a requester bug: do the write, flag it
               wr_d    = bus.dWEN;
               if (bus.dREN && bus.dWEN) begin
                  err_d = 1'b1;
               end
               // the streak only counts data grants that made a fetch wait
               if (bus.iREN) begin
                  streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
               end else begin
                  streak_d = '0;
               end
            end else if (bus.iREN) begin
               state_d  = IACC;
               addr_d   = bus.iaddr;
               streak_d = '0;
            end
         end
         IACC: begin
            if (bus.ramstate == RAM_ACCESS) begin
               iload_d = bus.ramload;
               ihit_d  = 1'b1;
               state_d = RESP;
            end else if (bus.ramstate == RAM_ERROR) begin
               // keep strobing; the RAM is expected to retry the access
               err_d = 1'b1;
            end
         end
         DACC: begin
            if (bus.ramstate == RAM_ACCESS) begin
               if (!wr_q) begin
                  dload_d = bus.ramload;
               end
               dhit_d  = 1'b1;
               state_d = RESP;
            end else if (bus.ramstate == RAM_ERROR) begin
               err_d = 1'b1;
            end
         end
         RESP: begin
            // requests are deliberately not sampled here so the requester
            // has one edge to drop or change its request after the hit
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched-request registers; reset abandons any access in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         store_q  <= '0;
         wr_q     <= 1'b0;
         streak_q <= '0;
         ihit_q   <= 1'b0;
         dhit_q   <= 1'b0;
         iload_q  <= '0;
         dload_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         store_q  <= store_d;
         wr_q     <= wr_d;
         streak_q <= streak_d;
         ihit_q   <= ihit_d;
         dhit_q   <= dhit_d;
         iload_q  <= iload_d;
         dload_q  <= dload_d;
         err_q    <= err_d;
      end
   end

   // RAM strobes are decoded from state; address/data hold their last latched values.
   assign bus.ramREN   = (state_q == IACC) | ((state_q == DACC) & ~wr_q);
   assign bus.ramWEN   = (state_q == DACC) & wr_q;
   assign bus.ramaddr  = addr_q;
   assign bus.ramstore = store_q;

   assign bus.ihit  = ihit_q;
   assign bus.dhit  = dhit_q;
   assign bus.iload = iload_q;
   assign bus.dload = dload_q;
   assign bus.err   = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: requester drivers, a behavioural RAM with
// random latency and error injection, a transaction-level grant model and a
// scoreboard monitor that checks every ihit/dhit against the model.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int WORD_W = 32;
   localparam int ADDR_W = 32;
   localparam int MAXS   = 4;
   localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACC = 2'd2, R_ERR = 2'd3;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   mem_arbiter_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

   mem_arbiter #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .MAX_DATA_STREAK(MAXS)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          is_d;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] store;
      logic [31:0] load;
      bit          errd;
   } exp_t;

   typedef struct {
      bit          wen;
      logic [31:0] addr;
      logic [31:0] store;
   } acc_t;

   exp_t sb[$];
   acc_t alog[$];
   logic [31:0] mem [logic [31:0]];

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   int          m_streak  = 0;
   bit          m_dual    = 1'b0;
   bit          ram_err   = 1'b0;
   logic [31:0] exp_iload = '0;
   logic [31:0] exp_dload = '0;
   bit          i_pend    = 1'b0;
   bit          d_pend    = 1'b0;
   bit          chk_spur  = 1'b1;
   bit          abort     = 1'b0;
   bit          got_i     = 1'b0;
   int          ren_cycles = 0;

   // RAM behaviour controls
   bit          ram_dir    = 1'b1;
   int          dir_errs   = 0;
   int          dir_wait   = 0;
   bit          ram_err_en = 1'b0;
   int          r_errs = 0, r_wait = 0, r_cnt = 0;
   bit          c_ren, c_wen;
   logic [31:0] c_addr, c_store;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   function automatic logic [31:0] rnd_addr();
      return 32'($urandom_range(0, 63)) << 2;
   endfunction

   // Behavioural RAM: ERROR cycles, then BUSY cycles, then ACCESS; noise when not strobed.
   always @(negedge CLK) begin
      acc_t a;
      if (RST) begin
         r_cnt = 0;
         bus.ramstate = R_FREE;
         bus.ramload  = '0;
      end else if (bus.ramREN || bus.ramWEN) begin
         if (r_cnt == 0) begin
            if (ram_dir) begin
               r_errs = dir_errs;
               r_wait = dir_wait;
            end else begin
               r_errs = (ram_err_en && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
               r_wait = int'($urandom_range(0, 3));
            end
            c_ren = bus.ramREN;  c_wen = bus.ramWEN;
            c_addr = bus.ramaddr; c_store = bus.ramstore;
         end else begin
            chk("strobe_addr_stable", 64'({bus.ramREN, bus.ramWEN, bus.ramaddr}), 64'({c_ren, c_wen, c_addr}));
            if (c_wen) chk("store_stable", 64'(bus.ramstore), 64'(c_store));
         end
         if (r_cnt < r_errs) begin
            bus.ramstate = R_ERR;
            bus.ramload  = $urandom;
            ram_err = 1'b1;
            r_cnt++;
         end else if (r_cnt < r_errs + r_wait) begin
            bus.ramstate = R_BUSY;
            bus.ramload  = $urandom;
            r_cnt++;
         end else begin
            bus.ramstate = R_ACC;
            bus.ramload  = mem_rd(bus.ramaddr);
            if (bus.ramWEN) mem[bus.ramaddr] = bus.ramstore;
            a.wen = bus.ramWEN; a.addr = bus.ramaddr; a.store = bus.ramstore;
            alog.push_back(a);
            r_cnt = 0;
         end
      end else begin
         bus.ramstate = 2'($urandom_range(0, 3));
         bus.ramload  = $urandom;
      end
   end

   // Scoreboard monitor: per-cycle invariants, and per-hit comparison with the model.
   bit   prev_i = 1'b0, prev_d = 1'b0;
   exp_t mon_e;
   acc_t mon_a;
   always @(negedge CLK) begin
      if (RST) begin
         prev_i = 1'b0;
         prev_d = 1'b0;
      end else begin
         if (bus.ramREN) ren_cycles++;
         chk("strobes_exclusive", 64'(bus.ramREN & bus.ramWEN), 64'(0));
         chk("hits_exclusive", 64'(bus.ihit & bus.dhit), 64'(0));
         if (prev_i) chk("ihit_single_cycle", 64'(bus.ihit), 64'(0));
         if (prev_d) chk("dhit_single_cycle", 64'(bus.dhit), 64'(0));
         if (chk_spur && sb.size() == 0)
            chk("no_strobe_without_request", 64'(bus.ramREN | bus.ramWEN), 64'(0));
         if (bus.ihit || bus.dhit) begin
            if (sb.size() == 0) begin
               chk("hit_with_empty_scoreboard", 64'(bus.ihit | bus.dhit), 64'(0));
            end else begin
               mon_e = sb.pop_front();
               chk("hit_kind_dhit", 64'(bus.dhit), 64'(mon_e.is_d));
               chk("strobes_low_in_resp", 64'({bus.ramREN, bus.ramWEN}), 64'(0));
               if (alog.size() == 0) begin
                  chk("hit_without_ram_access", 64'(bus.ihit | bus.dhit), 64'(0));
               end else begin
                  mon_a = alog.pop_front();
                  chk("ram_op_write", 64'(mon_a.wen), 64'(mon_e.wr));
                  chk("ram_addr", 64'(mon_a.addr), 64'(mon_e.addr));
                  if (mon_e.wr) chk("ram_store", 64'(mon_a.store), 64'(mon_e.store));
               end
               if (mon_e.is_d) begin
                  if (!mon_e.wr) exp_dload = mon_e.load;
               end else begin
                  exp_iload = mon_e.load;
               end
               chk("iload", 64'(bus.iload), 64'(exp_iload));
               chk("dload", 64'(bus.dload), 64'(exp_dload));
               chk("err", 64'(bus.err), 64'(mon_e.errd | ram_err));
            end
         end
         prev_i = bus.ihit;
         prev_d = bus.dhit;
      end
   end

   // Predict the next grant from the pending requests, then wait for it to complete.
   task automatic grant_one(input bit perturb);
      exp_t e;
      int   t;
      if (abort) return;
      e.is_d = d_pend && !(i_pend && m_streak == MAXS);
      if (e.is_d) begin
         e.wr    = bus.dWEN;
         e.addr  = bus.daddr;
         e.store = bus.dstore;
         e.load  = mem_rd(bus.daddr);
         if (bus.dREN && bus.dWEN) m_dual = 1'b1;
         m_streak = i_pend ? ((m_streak == MAXS) ? MAXS : m_streak + 1) : 0;
      end else begin
         e.wr    = 1'b0;
         e.addr  = bus.iaddr;
         e.store = '0;
         e.load  = mem_rd(bus.iaddr);
         m_streak = 0;
      end
      e.errd = m_dual;
      sb.push_back(e);
      t = 0;
      do begin @(negedge CLK); t++; end while (!(bus.ramREN || bus.ramWEN) && t < 20);
      chk("strobe_within_budget", 64'(bus.ramREN | bus.ramWEN), 64'(1));
      if (!(bus.ramREN || bus.ramWEN)) begin abort = 1'b1; return; end
      if (perturb) begin
         if (e.is_d) begin
            bus.daddr  = rnd_addr();
            bus.dstore = $urandom;
            if ($urandom_range(0, 3) == 0) begin bus.dREN = 1'b0; bus.dWEN = 1'b0; end
         end else begin
            bus.iaddr = rnd_addr();
            if ($urandom_range(0, 3) == 0) bus.iREN = 1'b0;
         end
      end
      t = 0;
      do begin @(negedge CLK); t++; end while (!(bus.ihit || bus.dhit) && t < 30);
      chk("hit_within_budget", 64'(bus.ihit | bus.dhit), 64'(1));
      if (!(bus.ihit || bus.dhit)) begin abort = 1'b1; return; end
      got_i = bus.ihit;
      if (e.is_d) begin d_pend = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; end
      else begin i_pend = 1'b0; bus.iREN = 1'b0; end
   endtask

   task automatic clear_model();
      sb.delete(); alog.delete();
      m_streak = 0; m_dual = 1'b0; ram_err = 1'b0;
      exp_iload = '0; exp_dload = '0;
      i_pend = 1'b0; d_pend = 1'b0;
   endtask

   task automatic reset_dut();
      bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_ihit", 64'(bus.ihit), 64'(0));
      chk("rst_dhit", 64'(bus.dhit), 64'(0));
      chk("rst_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'(0));
      chk("rst_err", 64'(bus.err), 64'(0));
      chk("rst_iload", 64'(bus.iload), 64'(0));
      chk("rst_dload", 64'(bus.dload), 64'(0));
      chk("rst_ramaddr", 64'(bus.ramaddr), 64'(0));
      chk("rst_ramstore", 64'(bus.ramstore), 64'(0));
      clear_model();
      RST = 1'b0;
   endtask

   task automatic random_phase(input int n, input bit allow_dual);
      int op;
      for (int k = 0; k < n && !abort; k++) begin
         if (!i_pend && $urandom_range(0, 2) != 0) begin
            bus.iaddr = rnd_addr(); bus.iREN = 1'b1; i_pend = 1'b1;
         end
         if (!d_pend && $urandom_range(0, 2) != 0) begin
            bus.daddr  = rnd_addr();
            bus.dstore = $urandom;
            op = int'($urandom_range(0, 9));
            bus.dWEN = (op < 4);
            bus.dREN = (op >= 4) || (allow_dual && op == 0);
            d_pend = 1'b1;
         end
         if (i_pend || d_pend) grant_one(1'b1);
         else @(negedge CLK);
      end
      for (int k = 0; k < 4 && (i_pend || d_pend) && !abort; k++) grant_one(1'b0);
   endtask

   task automatic test_ifetch();
      if (abort) return;
      ram_dir = 1'b1; dir_errs = 0; dir_wait = 2;
      mem[32'h40] = 32'h2010_FFFF;
      bus.iaddr = 32'h40; bus.iREN = 1'b1; i_pend = 1'b1;
      ren_cycles = 0;
      grant_one(1'b0);
      chk("ifetch_is_ihit", 64'(got_i), 64'(1));
      chk("ifetch_ren_cycles", 64'(ren_cycles), 64'(3));
      chk("ifetch_iload", 64'(bus.iload), 64'(32'h2010_FFFF));
      chk("ifetch_ramaddr", 64'(bus.ramaddr), 64'(32'h40));
   endtask

   task automatic test_write();
      if (abort) return;
      ram_dir = 1'b1; dir_errs = 0; dir_wait = 0;
      bus.daddr = 32'h200; bus.dstore = 32'hDEAD_BEEF;
      bus.dWEN = 1'b1; bus.dREN = 1'b0; d_pend = 1'b1;
      grant_one(1'b0);
      chk("write_is_dhit", 64'(got_i), 64'(0));
      chk("write_reached_ram", 64'(mem_rd(32'h200)), 64'(32'hDEAD_BEEF));
      chk("write_ramaddr", 64'(bus.ramaddr), 64'(32'h200));
      chk("write_ramstore", 64'(bus.ramstore), 64'(32'hDEAD_BEEF));
      chk("write_dload_unchanged", 64'(bus.dload), 64'(0));
   endtask

   task automatic test_streak();
      if (abort) return;
      ram_dir = 1'b1; dir_errs = 0; dir_wait = 0;
      bus.iaddr = 32'h80; bus.daddr = 32'h100;
      for (int k = 0; k < 10 && !abort; k++) begin
         if (!i_pend) begin bus.iREN = 1'b1; i_pend = 1'b1; end
         if (!d_pend) begin bus.dREN = 1'b1; bus.dWEN = 1'b0; d_pend = 1'b1; end
         grant_one(1'b0);
         chk("streak_grant_is_fetch", 64'(got_i), 64'(k == 4 || k == 9));
      end
      bus.dREN = 1'b0; d_pend = 1'b0;
   endtask

   task automatic test_error_retry();
      if (abort) return;
      chk("err_clear_before_ram_error", 64'(bus.err), 64'(0));
      ram_dir = 1'b1; dir_errs = 2; dir_wait = 0;
      bus.iaddr = 32'h44; bus.iREN = 1'b1; i_pend = 1'b1;
      ren_cycles = 0;
      grant_one(1'b0);
      chk("err_retry_ren_cycles", 64'(ren_cycles), 64'(3));
      chk("err_set_by_ram_error", 64'(bus.err), 64'(1));
      repeat (6) @(negedge CLK);
      chk("no_reissue_after_drop", 64'(ren_cycles), 64'(3));
   endtask

   task automatic test_dual();
      if (abort) return;
      ram_dir = 1'b1; dir_errs = 0; dir_wait = 1;
      bus.daddr = 32'h300; bus.dstore = 32'h1234_5678;
      bus.dREN = 1'b1; bus.dWEN = 1'b1; d_pend = 1'b1;
      grant_one(1'b0);
      chk("dual_write_reached_ram", 64'(mem_rd(32'h300)), 64'(32'h1234_5678));
      chk("dual_sets_err", 64'(bus.err), 64'(1));
      repeat (5) @(negedge CLK);
      chk("dual_err_sticky", 64'(bus.err), 64'(1));
   endtask

   task automatic test_reset_mid_dacc();
      int t;
      if (abort) return;
      chk("err_sticky_before_reset", 64'(bus.err), 64'(1));
      ram_dir = 1'b1; dir_errs = 0; dir_wait = 20;
      chk_spur = 1'b0;
      bus.daddr = 32'h400; bus.dstore = 32'hCAFE_F00D;
      bus.dREN = 1'b0; bus.dWEN = 1'b1;
      t = 0;
      do begin @(negedge CLK); t++; end while (!bus.ramWEN && t < 10);
      chk("ramwen_before_reset", 64'(bus.ramWEN), 64'(1));
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_dacc_ramwen", 64'(bus.ramWEN), 64'(0));
      chk("rst_dacc_ramren", 64'(bus.ramREN), 64'(0));
      chk("rst_dacc_dhit", 64'(bus.dhit), 64'(0));
      chk("rst_dacc_err", 64'(bus.err), 64'(0));
      chk("rst_dacc_dload", 64'(bus.dload), 64'(0));
      chk("rst_dacc_ramaddr", 64'(bus.ramaddr), 64'(0));
      RST = 1'b0;
      bus.dWEN = 1'b0;
      clear_model();
      @(negedge CLK);
      chk("idle_after_reset", 64'({bus.ramREN, bus.ramWEN}), 64'(0));
      chk_spur = 1'b1;
   endtask

   initial begin
      bus.iREN = 1'b0; bus.iaddr = '0;
      bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
      reset_dut();
      test_ifetch();
      test_write();
      test_streak();
      ram_dir = 1'b0; ram_err_en = 1'b0;
      if (!abort) random_phase(300, 1'b0);
      test_error_retry();
      if (!abort) reset_dut();
      test_dual();
      ram_dir = 1'b0; ram_err_en = 1'b1;
      if (!abort) random_phase(300, 1'b1);
      test_reset_mid_dacc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got time %0t, required finish before 500000", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
